// File: rtl/centroid_accumulating_pkg.sv
// centroid_accumulating_pkg: widths, FSM states and accumulator-entry types for the centroid accumulator.
package centroid_accumulating_pkg;
  localparam int centroid_num = 8;
  localparam int coord_num = 7;
  localparam int cordinate_width = 13;
  localparam int accum_cord_width = 22;
  localparam int count_width = 10;
  localparam int idx_width = 3;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  typedef logic [coord_num-1:0][accum_cord_width-1:0] acc_vec_t;
  typedef struct packed {
    acc_vec_t sum;
    logic [count_width-1:0] count;
  } entry_t;
endpackage

// File: rtl/centroid_accumulating_if.sv
// centroid_accumulating_if: point input stream, result output stream and pass control.
interface centroid_accumulating_if;
  import centroid_accumulating_pkg::*;
  logic start;
  logic point_valid;
  logic point_ready;
  logic [coord_num*cordinate_width-1:0] point_data;
  logic [idx_width-1:0] point_centroid;
  logic last_point;
  logic out_valid;
  logic out_ready;
  logic [idx_width-1:0] out_centroid;
  logic [coord_num*accum_cord_width-1:0] out_accumulator;
  logic [count_width-1:0] out_counter;
  logic done;
  logic overflow;
  modport master (
    output start, point_valid, point_data, point_centroid, last_point, out_ready,
    input point_ready, out_valid, out_centroid, out_accumulator, out_counter, done, overflow
  );
  modport slave (
    input start, point_valid, point_data, point_centroid, last_point, out_ready,
    output point_ready, out_valid, out_centroid, out_accumulator, out_counter, done, overflow
  );
endinterface

// File: rtl/centroid_accumulating_accum_lane_add.sv
// accum_lane_add: one coordinate lane, sign-extend and add; saturates when ACCUM_SAT_EN is defined.
module accum_lane_add
  import centroid_accumulating_pkg::*;
(
  input  logic [cordinate_width-1:0]  coord,
  input  logic [accum_cord_width-1:0] acc,
  output logic [accum_cord_width-1:0] sum,
  output logic                        ovf
);
`ifdef ACCUM_SAT_EN
  logic [accum_cord_width:0] wide;
  assign wide = {acc[accum_cord_width-1], acc}
              + {{(accum_cord_width+1-cordinate_width){coord[cordinate_width-1]}}, coord};
  // top two bits disagree exactly when the signed result left the range
  assign ovf = wide[accum_cord_width] ^ wide[accum_cord_width-1];
  assign sum = ovf ? {wide[accum_cord_width], {(accum_cord_width-1){~wide[accum_cord_width]}}}
                   : wide[accum_cord_width-1:0];
`else
  assign sum = acc + {{(accum_cord_width-cordinate_width){coord[cordinate_width-1]}}, coord};
  assign ovf = 1'b0;
`endif
endmodule

// File: rtl/centroid_accumulating.sv
// centroid_accumulating: per-centroid sum/count accumulation over a k-means pass, then in-order drain to the divider.
// Define ACCUM_SAT_EN for saturating per-coordinate sums; default build wraps modulo 2^accum_cord_width.
module centroid_accumulating
  import centroid_accumulating_pkg::*;
(
  input logic clk,
  input logic rst,
  centroid_accumulating_if.slave bus
);
  state_t state, state_n;
  entry_t bank [centroid_num];
  entry_t sel, upd, out_q;
  logic [idx_width-1:0] idx, idx_nxt;
  acc_vec_t lane_sum;
  logic [coord_num-1:0] lane_ovf;
  logic take, idx_bad, cnt_full, add_en, drain_go, out_take, last_out, ovf_q;
  assign take = bus.point_valid && state == ACCUM;
  assign idx_bad = int'(bus.point_centroid) >= centroid_num;
  // bank is read straight from the registers, so a point every cycle to one entry sees the prior update
  assign sel = idx_bad ? '0 : bank[bus.point_centroid];
  assign cnt_full = &sel.count;
  assign add_en = take && !idx_bad && !cnt_full;
  assign upd = '{sum: lane_sum, count: sel.count + count_width'(1)};
  assign drain_go = take && bus.last_point;
  assign out_take = state == DRAIN && bus.out_ready;
  assign last_out = idx == idx_width'(centroid_num - 1);
  assign idx_nxt = idx + idx_width'(1);
  for (genvar k = 0; k < coord_num; k++) begin : g_lane
    accum_lane_add u_lane (
      .coord(bus.point_data[k*cordinate_width +: cordinate_width]),
      .acc  (sel.sum[k]),
      .sum  (lane_sum[k]),
      .ovf  (lane_ovf[k])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.start) state_n = ACCUM;
    if (drain_go) state_n = DRAIN;
    if (out_take && last_out) state_n = DONE;
    if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < centroid_num; i++) bank[i] <= '0;
      idx <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        for (int i = 0; i < centroid_num; i++) bank[i] <= '0;
        ovf_q <= 1'b0;
      end
      if (add_en) bank[bus.point_centroid] <= upd;
      if (take && (idx_bad || cnt_full || (add_en && |lane_ovf))) ovf_q <= 1'b1;
      // entry 0 may be updated by the closing point itself, so forward that value
      if (drain_go) begin
        idx <= '0;
        out_q <= (add_en && bus.point_centroid == '0) ? upd : bank[0];
      end
      if (out_take) begin
        idx <= idx_nxt;
        out_q <= last_out ? '0 : bank[idx_nxt];
      end
    end
  end
  assign bus.point_ready = state == ACCUM;
  assign bus.out_valid = state == DRAIN;
  assign bus.done = state == DONE;
  assign bus.overflow = ovf_q;
  assign bus.out_centroid = idx;
  assign bus.out_accumulator = out_q.sum;
  assign bus.out_counter = out_q.count;
endmodule

// File: tb/tb_centroid_accumulating.sv
// tb_centroid_accumulating: randomized bench with an integer-arithmetic model of per-centroid sums and counts.
module tb_centroid_accumulating;
  import centroid_accumulating_pkg::*;
  localparam longint amax = (64'sd1 <<< (accum_cord_width - 1)) - 1;
  localparam longint amin = -amax - 1;
  localparam int cmax = (1 << count_width) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  centroid_accumulating_if bus();
  centroid_accumulating dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  longint msum [centroid_num][coord_num];
  int mcnt [centroid_num];
  bit movf;
  int cur [coord_num];

  function automatic logic [coord_num*accum_cord_width-1:0] exp_acc(int c);
    logic [coord_num*accum_cord_width-1:0] r;
    logic [63:0] t;
    for (int k = 0; k < coord_num; k++) begin
      t = msum[c][k];
      r[k*accum_cord_width +: accum_cord_width] = t[accum_cord_width-1:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < centroid_num; c++) begin
      mcnt[c] = 0;
      for (int k = 0; k < coord_num; k++) msum[c][k] = 0;
    end
    movf = 0;
  endtask

  task automatic model_point(int c);
    longint s;
    if (mcnt[c] == cmax) movf = 1;
    else begin
      for (int k = 0; k < coord_num; k++) begin
        s = msum[c][k] + longint'(cur[k]);
`ifdef ACCUM_SAT_EN
        if (s > amax) begin s = amax; movf = 1; end
        if (s < amin) begin s = amin; movf = 1; end
`endif
        msum[c][k] = s;
      end
      mcnt[c]++;
    end
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.point_valid = 0; bus.point_data = '0; bus.point_centroid = '0;
    bus.last_point = 0; bus.out_ready = 0;
  endtask

  task automatic start_pass();
    @(posedge clk); #1 bus.start = 1;
    @(posedge clk); #1 bus.start = 0;
    model_clear();
  endtask

  task automatic send_point(int c, bit last);
    int n = 0;
    bus.point_valid = 1;
    bus.point_centroid = idx_width'(c);
    bus.last_point = last;
    for (int k = 0; k < coord_num; k++)
      bus.point_data[k*cordinate_width +: cordinate_width] = cordinate_width'(cur[k]);
    while (!bus.point_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n == 20) begin errors++; $display("FAIL point_ready timeout: ready=%0b required=1", bus.point_ready); end
    @(posedge clk); #1;
    model_point(c);
    bus.point_valid = 0;
    bus.last_point = 0;
  endtask

  task automatic rand_coords(int lo, int hi);
    for (int k = 0; k < coord_num; k++) cur[k] = int'($urandom_range(hi - lo, 0)) + lo;
  endtask

  task automatic drain(bit toggle);
    int got = 0, cyc = 0, vcyc = 0;
    bit stalled = 0;
    logic [idx_width+count_width+coord_num*accum_cord_width-1:0] snap;
    bus.out_ready = toggle ? 1'($urandom_range(1, 0)) : 1'b1;
    while (got < centroid_num && cyc < 400) begin
      @(negedge clk); cyc++;
      if (bus.out_valid) begin
        vcyc++;
        if (stalled) begin
          checks++;
          if ({bus.out_centroid, bus.out_counter, bus.out_accumulator} !== snap) begin
            errors++; $display("FAIL stall_stable: got %h required %h", {bus.out_centroid, bus.out_counter, bus.out_accumulator}, snap);
          end
        end
        if (bus.out_ready) begin
          checks++;
          if (bus.out_centroid !== idx_width'(got) || bus.out_counter !== count_width'(mcnt[got]) || bus.out_accumulator !== exp_acc(got)) begin
            errors++;
            $display("FAIL drain_word: idx=%0d cnt=%0d acc=%h required idx=%0d cnt=%0d acc=%h",
                     bus.out_centroid, bus.out_counter, bus.out_accumulator, got, mcnt[got], exp_acc(got));
          end
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          snap = {bus.out_centroid, bus.out_counter, bus.out_accumulator};
        end
      end
      @(posedge clk); #1;
      bus.out_ready = toggle ? 1'($urandom_range(1, 0)) : 1'b1;
    end
    checks++;
    if (got != centroid_num) begin errors++; $display("FAIL drain_timeout: words=%0d required=%0d", got, centroid_num); end
    if (!toggle) begin
      checks++;
      if (vcyc != centroid_num) begin errors++; $display("FAIL drain_cycles: got %0d required %0d", vcyc, centroid_num); end
    end
    bus.out_ready = 0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.overflow !== movf) begin
      errors++; $display("FAIL done_pulse: done=%0b valid=%0b ovf=%0b required 1 0 %0b", bus.done, bus.out_valid, bus.overflow, movf);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.point_ready !== 1'b0) begin
      errors++; $display("FAIL back_to_idle: done=%0b ready=%0b required 0 0", bus.done, bus.point_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.point_ready, bus.out_valid, bus.done, bus.overflow, bus.out_centroid, bus.out_counter, bus.out_accumulator} !== '0) begin
      errors++; $display("FAIL reset_outputs: ready=%0b valid=%0b done=%0b ovf=%0b required all 0", bus.point_ready, bus.out_valid, bus.done, bus.overflow);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_basic();
    start_pass();
    for (int k = 0; k < coord_num; k++) cur[k] = 5;
    send_point(2, 0); send_point(2, 0); send_point(2, 1);
    drain(0);
  endtask

  task automatic test_negative();
    start_pass();
    for (int k = 0; k < coord_num; k++) cur[k] = -4096;
    send_point(0, 0); send_point(0, 1);
    drain(0);
  endtask

  task automatic test_random_stall();
    start_pass();
    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
      rand_coords(-4096, 4095);
      send_point(int'($urandom_range(centroid_num - 1, 0)), p == 39);
    end
    drain(1);
  endtask

  task automatic test_back_to_back();
    int c = int'($urandom_range(centroid_num - 1, 0));
    start_pass();
    for (int p = 0; p < 20; p++) begin
      rand_coords(-4096, 4095);
      send_point(p % 4 == 3 ? int'($urandom_range(centroid_num - 1, 0)) : c, p == 19);
    end
    drain(0);
  endtask

  task automatic test_count_overflow();
    start_pass();
    for (int p = 0; p < 1024; p++) begin
      rand_coords(-100, 100);
      send_point(5, p == 1023);
    end
    drain(0);
  endtask

  task automatic test_wrap();
    start_pass();
    for (int k = 0; k < coord_num; k++) cur[k] = 4095;
    for (int p = 0; p < 600; p++) send_point(1, p == 599);
    drain(0);
  endtask

  task automatic test_rst_mid();
    start_pass();
    for (int p = 0; p < 5; p++) begin rand_coords(-4096, 4095); send_point(int'($urandom_range(7, 0)), 0); end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({bus.point_ready, bus.out_valid, bus.done, bus.overflow, bus.out_centroid, bus.out_counter, bus.out_accumulator} !== '0) begin
      errors++; $display("FAIL rst_mid_accum: ready=%0b valid=%0b required 0 0", bus.point_ready, bus.out_valid);
    end
    @(posedge clk); #1 rst = 0;
    model_clear();
    start_pass();
    for (int p = 0; p < 6; p++) begin rand_coords(-4096, 4095); send_point(int'($urandom_range(7, 0)), p == 5); end
    bus.start = 1;
    @(posedge clk); #1 bus.start = 0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.point_ready !== 1'b0 || bus.out_centroid !== '0) begin
      errors++; $display("FAIL start_in_drain: valid=%0b ready=%0b idx=%0d required 1 0 0", bus.out_valid, bus.point_ready, bus.out_centroid);
    end
    @(posedge clk); #1;
    drain(0);
    start_pass();
    for (int p = 0; p < 4; p++) begin rand_coords(-4096, 4095); send_point(int'($urandom_range(7, 0)), p == 3); end
    bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    bus.out_ready = 0;
    @(negedge clk);
    checks++;
    if ({bus.point_ready, bus.out_valid, bus.done, bus.overflow, bus.out_centroid, bus.out_counter, bus.out_accumulator} !== '0) begin
      errors++; $display("FAIL rst_mid_drain: valid=%0b idx=%0d cnt=%0d required all 0", bus.out_valid, bus.out_centroid, bus.out_counter);
    end
    @(posedge clk); #1 rst = 0;
    start_pass();
    rand_coords(-4096, 4095);
    send_point(int'($urandom_range(7, 0)), 1);
    drain(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_random_stall();
    test_back_to_back();
    test_count_overflow();
    test_wrap();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
